// File: rtl/mem_access.sv
// mem_access: memory-access stage; runs the load/store/UART receive an execution bundle asks for and forwards it to writeback
// Ports:
//   CLK, reset                    clock and synchronous active-high reset
//   distinct + control/data       execution bundle (AorF, RegWrite, MemWrite, MemRead, UARTtoReg, MemtoReg, result, register_data, rdist)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   data-memory port, read data valid MEM_LATENCY cycles after the request
//   uart_rx_data/valid/ready      UART receive handshake
//   distinct_next + *_next, mem_data              finished bundle to writeback, distinct_next pulses once per bundle
//   busy                          high while a load or UART receive is in flight
// Build option: define MEM_UART_EN to build the UART receive path; otherwise UARTtoReg ops complete as plain ops.
module mem_access #(
  parameter int DATA_MEM_WIDTH = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      distinct,
  input  logic                      AorF,
  input  logic                      RegWrite,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic                      UARTtoReg,
  input  logic [1:0]                MemtoReg,
  input  logic [31:0]               result,
  input  logic [31:0]               register_data,
  input  logic [4:0]                rdist,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [DATA_MEM_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  input  logic [7:0]                uart_rx_data,
  input  logic                      uart_rx_valid,
  output logic                      uart_rx_ready,
  output logic                      distinct_next,
  output logic                      AorF_next,
  output logic                      RegWrite_next,
  output logic [1:0]                MemtoReg_next,
  output logic [4:0]                rdist_next,
  output logic [31:0]               result_next,
  output logic [31:0]               mem_data,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, READ_WAIT, UART_WAIT} state_t;
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [40:0] r_hold;
  logic [40:0] w_in;
  logic        w_load;
  logic        w_store;
  assign w_in = {AorF, RegWrite, MemtoReg, rdist, result};
  // UARTtoReg outranks memory ops even when the UART path is not built
  assign w_load = MemRead & ~UARTtoReg;
  assign w_store = MemWrite & ~MemRead & ~UARTtoReg;
`ifdef MEM_UART_EN
  assign uart_rx_ready = r_state == UART_WAIT;
`else
  logic w_unused;
  assign w_unused = ^{uart_rx_data, uart_rx_valid};
  assign uart_rx_ready = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_hold <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      distinct_next <= 1'b0;
      {AorF_next, RegWrite_next, MemtoReg_next, rdist_next, result_next} <= '0;
      mem_data <= '0;
      busy <= 1'b0;
    end else begin
      distinct_next <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (r_state)
        IDLE: if (distinct) begin
`ifdef MEM_UART_EN
          if (UARTtoReg) begin
            r_state <= UART_WAIT;
            r_hold <= w_in;
            busy <= 1'b1;
          end else
`endif
          if (w_load) begin
            r_state <= READ_WAIT;
            r_hold <= w_in;
            r_cnt <= 3'(MEM_LATENCY);
            busy <= 1'b1;
            mem_en <= 1'b1;
            mem_addr <= result[DATA_MEM_WIDTH-1:0];
          end else begin
            distinct_next <= 1'b1;
            {AorF_next, RegWrite_next, MemtoReg_next, rdist_next, result_next} <= w_in;
            mem_data <= '0;
            if (w_store) begin
              mem_en <= 1'b1;
              mem_we <= 1'b1;
              mem_addr <= result[DATA_MEM_WIDTH-1:0];
              mem_wdata <= register_data;
            end
          end
        end
        // counter reaches zero on the edge where read data is valid
        READ_WAIT: if (r_cnt == 3'd0) begin
          r_state <= IDLE;
          busy <= 1'b0;
          distinct_next <= 1'b1;
          {AorF_next, RegWrite_next, MemtoReg_next, rdist_next, result_next} <= r_hold;
          mem_data <= mem_rdata;
        end else r_cnt <= r_cnt - 3'd1;
`ifdef MEM_UART_EN
        UART_WAIT: if (uart_rx_valid) begin
          r_state <= IDLE;
          busy <= 1'b0;
          distinct_next <= 1'b1;
          {AorF_next, RegWrite_next, MemtoReg_next, rdist_next, result_next} <= r_hold;
          mem_data <= {24'b0, uart_rx_data};
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for mem_access with a memory device model and a bundle-level reference
module tb_mem_access;
  localparam int L = 2;
`ifdef MEM_UART_EN
  localparam bit UART_ON = 1'b1;
`else
  localparam bit UART_ON = 1'b0;
`endif
  logic CLK = 0, reset = 1, distinct = 0;
  logic AorF = 0, RegWrite = 0, MemWrite = 0, MemRead = 0, UARTtoReg = 0;
  logic [1:0] MemtoReg = 0;
  logic [31:0] result = 0, register_data = 0, mem_rdata = 0;
  logic [4:0] rdist = 0;
  logic [7:0] uart_rx_data = 0;
  logic uart_rx_valid = 0;
  logic mem_en, mem_we, uart_rx_ready, distinct_next, AorF_next, RegWrite_next, busy;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, result_next, mem_data;
  logic [1:0] MemtoReg_next;
  logic [4:0] rdist_next;

  mem_access #(.DATA_MEM_WIDTH(16), .MEM_LATENCY(L)) dut (
    .CLK(CLK), .reset(reset), .distinct(distinct), .AorF(AorF), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .UARTtoReg(UARTtoReg), .MemtoReg(MemtoReg),
    .result(result), .register_data(register_data), .rdist(rdist),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .distinct_next(distinct_next), .AorF_next(AorF_next), .RegWrite_next(RegWrite_next),
    .MemtoReg_next(MemtoReg_next), .rdist_next(rdist_next), .result_next(result_next),
    .mem_data(mem_data), .busy(busy));

  always #5 CLK = ~CLK;

  typedef struct {int cyc; logic [40:0] b; logic [31:0] d;} exp_t;
  typedef struct {int cyc; logic we; logic [15:0] a; logic [31:0] wd;} req_t;
  exp_t exp_q[$];
  req_t req_q[$];
  logic [31:0] model_mem [logic [15:0]];
  logic [31:0] dev_mem [logic [15:0]];
  logic [31:0] rd_sched [int];
  int cyc = 0, checks = 0, errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {a, ~a} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", n, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int c, input logic [40:0] b, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.b = b; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_req(input int c, input logic we, input logic [15:0] a, input logic [31:0] wd);
    req_t r;
    r.cyc = c; r.we = we; r.a = a; r.wd = wd;
    req_q.push_back(r);
  endtask

  // memory device: read data is valid exactly MEM_LATENCY cycles after the request cycle, garbage otherwise
  always @(negedge CLK) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) dev_mem[mem_addr] = mem_wdata;
    if (mem_en === 1'b1 && mem_we === 1'b0)
      rd_sched[cyc + L] = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : dflt(mem_addr);
    mem_rdata = rd_sched.exists(cyc) ? rd_sched[cyc] : $urandom;
  end

  // monitor: memory requests and completed bundles are popped and compared against the scoreboard
  always @(negedge CLK) begin
    req_t r;
    exp_t e;
    if (req_q.size() != 0 && req_q[0].cyc < cyc) begin
      chk("req_missing", 64'(req_q[0].cyc), 64'(cyc));
      void'(req_q.pop_front());
    end
    if (mem_en === 1'b1) begin
      if (req_q.size() == 0) chk("req_spurious", 1, 0);
      else begin
        r = req_q.pop_front();
        chk("req_cycle", 64'(cyc), 64'(r.cyc));
        chk("req_we", 64'(mem_we), 64'(r.we));
        chk("req_addr", 64'(mem_addr), 64'(r.a));
        if (r.we) chk("req_wdata", 64'(mem_wdata), 64'(r.wd));
      end
    end
    if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      chk("done_missing", 64'(exp_q[0].cyc), 64'(cyc));
      void'(exp_q.pop_front());
    end
    if (distinct_next === 1'b1) begin
      if (exp_q.size() == 0) chk("done_spurious", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("done_bundle", 64'({AorF_next, RegWrite_next, MemtoReg_next, rdist_next, result_next}), 64'(e.b));
        chk("done_mem_data", 64'(mem_data), 64'(e.d));
      end
    end
  end

  // called at a negedge with the stage idle; returns at the negedge where the next op may be driven
  task automatic issue(input bit u, input bit r, input bit w, input logic [31:0] res, input logic [31:0] rd,
                       input logic [4:0] rdn, input int d, input logic [7:0] ub, input bit abort);
    logic [40:0] b;
    logic [31:0] data;
    logic [15:0] a;
    int n;
    AorF = 1'($urandom); RegWrite = 1'($urandom); MemtoReg = 2'($urandom);
    result = res; register_data = rd; rdist = rdn;
    UARTtoReg = u; MemRead = r; MemWrite = w; distinct = 1;
    uart_rx_valid = 1'($urandom); uart_rx_data = 8'($urandom);
    b = {AorF, RegWrite, MemtoReg, rdn, res};
    n = cyc + 1;
    a = res[15:0];
    if (u && UART_ON) begin
      push_exp(n + d + 1, b, {24'b0, ub});
      @(negedge CLK);
      distinct = 0;
      for (int k = 0; k <= d; k++) begin
        chk("uart_busy", 64'(busy), 1);
        chk("uart_ready", 64'(uart_rx_ready), 1);
        uart_rx_valid = (k == d);
        uart_rx_data = (k == d) ? ub : 8'($urandom);
        @(negedge CLK);
      end
      uart_rx_valid = 0;
      chk("uart_busy_end", 64'(busy), 0);
    end else if (!u && r) begin
      data = model_mem.exists(a) ? model_mem[a] : dflt(a);
      push_req(n, 1'b0, a, 32'h0);
      if (!abort) push_exp(n + L + 1, b, data);
      @(negedge CLK);
      distinct = 0;
      if (abort) begin
        reset = 1;
        @(negedge CLK);
        reset = 0;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_outs", 64'({distinct_next, mem_en, uart_rx_ready}), 0);
        repeat (L + 2) @(negedge CLK);
      end else begin
        for (int k = 0; k <= L; k++) begin
          chk("load_busy", 64'(busy), 1);
          distinct = (k == 0);
          MemRead = 1'($urandom); MemWrite = 1'($urandom); UARTtoReg = 1'($urandom);
          result = $urandom; rdist = 5'($urandom);
          @(negedge CLK);
        end
        distinct = 0;
        chk("load_busy_end", 64'(busy), 0);
      end
    end else begin
      if (!u && w) begin
        model_mem[a] = rd;
        push_req(n, 1'b1, a, rd);
      end
      push_exp(n, b, 32'h0);
      @(negedge CLK);
      distinct = 0;
      if (u) chk("uart_off_ready", 64'(uart_rx_ready), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit u, r, w;
    logic [31:0] res;
    repeat (3) @(negedge CLK);
    reset = 0;
    repeat (5) @(negedge CLK);
    chk("rst_ctrl", 64'({mem_en, mem_we, uart_rx_ready, distinct_next, AorF_next, RegWrite_next, MemtoReg_next, busy}), 0);
    chk("rst_addr_rdist", 64'({mem_addr, rdist_next}), 0);
    chk("rst_wdata", 64'(mem_wdata), 0);
    chk("rst_result", 64'(result_next), 0);
    chk("rst_mem_data", 64'(mem_data), 0);
    issue(0, 0, 0, 32'h1234, 32'h0, 5'd7, 0, 8'h0, 0);
    chk("plain_no_mem", 64'(mem_en), 0);
    issue(0, 0, 1, 32'h0001_0010, 32'hDEADBEEF, 5'd3, 0, 8'h0, 0);
    issue(0, 0, 1, 32'h0000_0040, 32'hCAFEF00D, 5'd1, 0, 8'h0, 0);
    issue(0, 1, 0, 32'hFFFF_0040, 32'h0, 5'd9, 0, 8'h0, 0);
    issue(1, 1, 1, 32'h0000_0077, 32'h0, 5'd4, 4, 8'hA5, 0);
    issue(1, 0, 0, 32'h0000_0078, 32'h0, 5'd5, 0, 8'h3C, 0);
    issue(0, 1, 0, 32'h0000_0010, 32'h0, 5'd2, 0, 8'h0, 1);
    issue(0, 0, 0, 32'h5555_AAAA, 32'h0, 5'd30, 0, 8'h0, 0);
    issue(0, 1, 0, 32'h0000_0010, 32'h0, 5'd2, 0, 8'h0, 0);
    for (int i = 0; i < 300; i++) begin
      u = ($urandom % 6) == 0;
      r = ($urandom % 3) == 0;
      w = ($urandom % 3) == 0;
      res = $urandom;
      if ($urandom % 4 != 0) res[15:4] = '0;
      issue(u, r, w, res, $urandom, 5'($urandom), int'($urandom % 4), 8'($urandom), 0);
    end
    repeat (10) @(negedge CLK);
    chk("drain", 64'(exp_q.size() + req_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage that consumes the execution stage's result bundle, performs the data-memory load/store or UART receive it requests, and forwards a single-cycle `distinct_next` pulse with the finished bundle to the writeback stage. It is the downstream end of the execution-stage output handshake (`distinct_next`/`result`/`register_data`/`rdist`). It holds `busy` high while a multi-cycle operation is in flight so the pipeline controller can stall upstream.

## Interface
- `DATA_MEM_WIDTH`, 16: word-address width of data memory.
- `MEM_LATENCY`, 2: cycles from the `mem_en` request cycle to valid `mem_rdata`, 1..4.
- `CLK` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `distinct` in 1: one-cycle pulse, execution bundle valid this cycle.
- `AorF`, `RegWrite`, `MemWrite`, `MemRead`, `UARTtoReg` in 1 each: control from execution.
- `MemtoReg` in 2: writeback source select, passed through.
- `result` in 32: ALU/FPU result; also the memory address.
- `register_data` in 32: store data.
- `rdist` in 5: destination register.
- `mem_en`, `mem_we` out 1: data-memory request and write enable.
- `mem_addr` out DATA_MEM_WIDTH: word address.
- `mem_wdata` out 32: store data.
- `mem_rdata` in 32: load data.
- `uart_rx_data` in 8, `uart_rx_valid` in 1, `uart_rx_ready` out 1: UART receive handshake.
- `distinct_next` out 1: one-cycle pulse, output bundle valid.
- `AorF_next`, `RegWrite_next` out 1; `MemtoReg_next` out 2; `rdist_next` out 5: registered pass-through.
- `result_next` out 32: registered `result`.
- `mem_data` out 32: load data, zero-extended UART byte, or 0.
- `busy` out 1: stage occupied; `distinct` is ignored while high.

## Operation
- States: IDLE, READ_WAIT, UART_WAIT. All outputs registered except `uart_rx_ready`, which equals (state == UART_WAIT).
- IDLE with `distinct`=1 captures the bundle. Class priority: `UARTtoReg` > `MemRead` > `MemWrite` > plain.
- Plain: next edge drives `distinct_next`=1 with the pass-through fields. `mem_data`=0. State stays IDLE.
- Store: same edge as plain. `mem_en`=`mem_we`=1 for exactly one cycle. `mem_addr`=`result[DATA_MEM_WIDTH-1:0]`; upper bits are ignored with no fault. `mem_wdata`=`register_data`.
- Load: `mem_en`=1, `mem_we`=0 for one cycle, then enter READ_WAIT with `busy`=1. A down-counter loaded with `MEM_LATENCY` samples `mem_rdata` when it expires, then drives `distinct_next` and returns to IDLE.
- UART: enter UART_WAIT with `busy`=1. On an edge with `uart_rx_valid`&&`uart_rx_ready`: `mem_data`={24'b0, `uart_rx_data`}, `distinct_next`=1, return to IDLE. Wait has no limit.
- `distinct` while `busy`=1 is a protocol violation: ignored, no state change.
- Reset in any state: state←IDLE, counter cleared, any in-flight read or UART wait abandoned. No `distinct_next` is emitted for it. Late `mem_rdata` is discarded.

## Timing
- Reset value of every output is 0, including `mem_*`, `busy`, `uart_rx_ready`, and the `*_next` fields.
- Acceptance at edge N.
- Plain/store: `distinct_next` high in the cycle after edge N, for one cycle. Store request is in the same cycle.
- Load: request in cycle N..N+1. `mem_rdata` is sampled at edge N+1+MEM_LATENCY, so `distinct_next` is high after that edge. Total latency MEM_LATENCY+1. `busy` is high from edge N until edge N+1+MEM_LATENCY.
- UART: earliest completion is edge N+1, if `uart_rx_valid` is already high in cycle N..N+1.
- Back-to-back: a new `distinct` is accepted in the same cycle `distinct_next` is high, once `busy`=0. Plain ops sustain 1 per cycle.
- `*_next` fields hold their values until the next completion. Only `distinct_next` pulses.

## Configuration
- `MEM_UART_EN` defined: UART_WAIT path as above.
- `MEM_UART_EN` undefined: UART_WAIT is not built. `UARTtoReg` ops complete as plain with `mem_data`=0. `uart_rx_ready` is tied 0.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `busy`=0.
- Plain op, `result`=32'h1234, `rdist`=7 → next cycle `distinct_next`=1, `result_next`=32'h1234, `rdist_next`=7, `mem_en`=0.
- Store, `result`=32'h0001_0010, `register_data`=32'hDEADBEEF → one cycle with `mem_we`=1, `mem_addr`=16'h0010, `mem_wdata`=32'hDEADBEEF; `distinct_next` pulses in that same cycle.
- Load, MEM_LATENCY=2, model returns 32'hCAFEF00D → `distinct_next` pulses 3 cycles after acceptance with `mem_data`=32'hCAFEF00D. A `distinct` pulse during `busy` is ignored.
- UART op, `uart_rx_valid` asserted 4 cycles later with byte 8'hA5 → `uart_rx_ready` high throughout the wait; `mem_data`=32'h000000A5 on completion. With the macro off: immediate completion, `mem_data`=0.
- Reset asserted mid-READ_WAIT → no `distinct_next`, state IDLE, a following plain op completes normally.
